// File: rtl/mult_div_unit_if.sv
// Operand/control and HI/LO result bundle between the MIPS datapath and mult_div_unit.
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, hi_we, lo_we, wdata,
                  input  busy, done, hi, lo);
  modport slave  (input  start, op, a, b, hi_we, lo_we, wdata,
                  output busy, done, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: one result bit per clock on unsigned magnitudes,
// with sign correction applied in a single FIX cycle.
module mult_div_unit #(parameter int WIDTH = 32) (
  input  logic          clk,
  input  logic          reset,
  mult_div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'b00, CALC = 2'b01, FIX = 2'b10} state_t;

  state_t             state, nextState;
  logic [CW-1:0]      counter;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   operand;
  logic               isDiv, negQ, negR;
  logic               busyReg, doneReg;
  logic [WIDTH-1:0]   hiReg, loReg;

  logic               signedOp, divZero;
  logic [WIDTH-1:0]   magA, magB;
  logic               startNegQ, startNegR;
  logic [WIDTH:0]     stepSum, shifted, diff;
  logic [2*WIDTH-1:0] accNext, prodFix;
  logic [WIDTH-1:0]   quoFix, remFix;

  assign bus.busy = busyReg;
  assign bus.done = doneReg;
  assign bus.hi   = hiReg;
  assign bus.lo   = loReg;

  // Start-edge operand conditioning: magnitudes and result signs
  always_comb begin
    signedOp = ~bus.op[0];
    divZero  = bus.op[1] && (bus.b == {WIDTH{1'b0}});
    if (divZero) begin
      // Raw dividend with zero divisor makes the restoring loop yield quotient=~0, remainder=a
      magA      = bus.a;
      magB      = bus.b;
      startNegQ = 1'b0;
      startNegR = 1'b0;
    end else begin
      magA      = (signedOp && bus.a[WIDTH-1]) ? (~bus.a + {{(WIDTH-1){1'b0}}, 1'b1}) : bus.a;
      magB      = (signedOp && bus.b[WIDTH-1]) ? (~bus.b + {{(WIDTH-1){1'b0}}, 1'b1}) : bus.b;
      startNegQ = signedOp && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      startNegR = signedOp && bus.a[WIDTH-1];
    end
  end

  // One iteration: shift-add for multiply, restoring shift-subtract for divide
  always_comb begin
    stepSum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    shifted = acc[2*WIDTH-1:WIDTH-1];
    diff    = shifted - {1'b0, operand};
    if (isDiv) begin
      if (shifted >= {1'b0, operand}) begin
        accNext = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        accNext = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      accNext = {stepSum, acc[WIDTH-1:1]};
    end
  end

  // Sign correction of the finished magnitude result
  always_comb begin
    prodFix = negQ ? (~acc + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc;
    quoFix  = negQ ? (~acc[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1}) : acc[WIDTH-1:0];
    remFix  = negR ? (~acc[2*WIDTH-1:WIDTH] + {{(WIDTH-1){1'b0}}, 1'b1}) : acc[2*WIDTH-1:WIDTH];
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    nextState = bus.start ? CALC : IDLE;
      CALC:    nextState = (counter == LAST) ? FIX : CALC;
      FIX:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Datapath, HI/LO and handshake registers
  always_ff @(posedge clk) begin
    if (reset) begin
      counter <= {CW{1'b0}};
      acc     <= {(2*WIDTH){1'b0}};
      operand <= {WIDTH{1'b0}};
      isDiv   <= 1'b0;
      negQ    <= 1'b0;
      negR    <= 1'b0;
      busyReg <= 1'b0;
      doneReg <= 1'b0;
      hiReg   <= {WIDTH{1'b0}};
      loReg   <= {WIDTH{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          doneReg <= 1'b0;
          if (bus.hi_we) hiReg <= bus.wdata;
          if (bus.lo_we) loReg <= bus.wdata;
          if (bus.start) begin
            busyReg <= 1'b1;
            counter <= {CW{1'b0}};
            acc     <= {{WIDTH{1'b0}}, magA};
            operand <= magB;
            isDiv   <= bus.op[1];
            negQ    <= startNegQ;
            negR    <= startNegR;
          end else begin
            busyReg <= 1'b0;
          end
        end
        CALC: begin
          doneReg <= 1'b0;
          acc     <= accNext;
          counter <= counter + {{(CW-1){1'b0}}, 1'b1};
        end
        FIX: begin
          busyReg <= 1'b0;
          doneReg <= 1'b1;
          if (isDiv) begin
            hiReg <= remFix;
            loReg <= quoFix;
          end else begin
            hiReg <= prodFix[2*WIDTH-1:WIDTH];
            loReg <= prodFix[WIDTH-1:0];
          end
        end
        default: begin
          busyReg <= 1'b0;
          doneReg <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus random operations
// compared against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  mult_div_unit_if #(.WIDTH(32)) bus();
  mult_div_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Architectural result {hi, lo}
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: r = 64'(sa * sb);
      2'b01: r = {32'h0, a} * {32'h0, b};
      2'b10: r = (b == 32'h0) ? {a, 32'hFFFFFFFF} : {32'(sa % sb), 32'(sa / sb)};
      default: r = (b == 32'h0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
    endcase
    return r;
  endfunction

  // Run one op; optional restart pulse at cycle 5, MT writes at cycle 3, MT write with start
  task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit restart, input bit mtBusy, input bit mtStart);
    int n, busyLow, changes;
    logic [31:0] hiHold, loHold;
    logic [63:0] exp;
    exp = model(op, a, b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    bus.hi_we = mtStart; bus.lo_we = mtStart; bus.wdata = 32'hA5A5A5A5;
    @(negedge clk);
    bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    hiHold = bus.hi; loHold = bus.lo;
    n = 0; busyLow = 0; changes = 0;
    while (!bus.done && n < 100) begin
      if (!bus.busy) busyLow++;
      if (bus.hi !== hiHold || bus.lo !== loHold) changes++;
      bus.start = restart && (n == 5);
      if (bus.start) begin bus.op = 2'b01; bus.a = 32'h5; bus.b = 32'h9; end
      bus.hi_we = mtBusy && (n == 3);
      bus.lo_we = mtBusy && (n == 3);
      bus.wdata = 32'hDEADBEEF;
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    checkVal("latency", 64'(n), 64'd33);
    checkVal("busy_during_op", 64'(busyLow), 64'd0);
    checkVal("hilo_stable", 64'(changes), 64'd0);
    checkVal("busy_after", {63'd0, bus.busy}, 64'd0);
    checkVal("result_hilo", {bus.hi, bus.lo}, exp);
    @(negedge clk);
    checkVal("done_pulse_width", {63'd0, bus.done}, 64'd0);
    if (restart) begin
      n = 0;
      repeat (40) begin
        @(negedge clk);
        if (bus.done) n++;
      end
      checkVal("restart_ignored", 64'(n), 64'd0);
    end
  endtask

  initial begin
    int dones;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    logic [31:0] loSave;
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = 32'h0; bus.b = 32'h0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkVal("reset_state", {60'd0, bus.busy, bus.done, |bus.hi, |bus.lo}, 64'd0);

    runOp(2'b00, 32'h7, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0);
    checkVal("mult_neg", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFEB);
    runOp(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    checkVal("multu_max", {bus.hi, bus.lo}, 64'hFFFFFFFE_00000001);
    runOp(2'b10, 32'hFFFFFFF9, 32'h2, 1'b0, 1'b0, 1'b0);
    checkVal("div_neg", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFD);
    runOp(2'b11, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
    checkVal("divu", {bus.hi, bus.lo}, {32'd2, 32'd14});
    runOp(2'b11, 32'd100, 32'd0, 1'b0, 1'b0, 1'b0);
    checkVal("divu_zero", {bus.hi, bus.lo}, {32'd100, 32'hFFFFFFFF});
    runOp(2'b10, 32'hFFFFFF9C, 32'd0, 1'b0, 1'b0, 1'b0);
    checkVal("div_zero_neg", {bus.hi, bus.lo}, {32'hFFFFFF9C, 32'hFFFFFFFF});
    runOp(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    checkVal("div_overflow", {bus.hi, bus.lo}, {32'h0, 32'h80000000});

    // MT writes in IDLE, and ignored while busy
    loSave = bus.lo;
    @(negedge clk); bus.hi_we = 1'b1; bus.wdata = 32'h1234;
    @(negedge clk); bus.hi_we = 1'b0;
    checkVal("mthi", {bus.hi, bus.lo}, {32'h1234, loSave});
    checkVal("mt_no_done", {63'd0, bus.done}, 64'd0);
    @(negedge clk); bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h55AA;
    @(negedge clk); bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    checkVal("mt_both", {bus.hi, bus.lo}, {32'h55AA, 32'h55AA});
    runOp(2'b01, 32'd6, 32'd9, 1'b0, 1'b1, 1'b0);
    runOp(2'b00, 32'hFFFFFFFE, 32'd5, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of CALC aborts the op
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd3; bus.b = 32'd4;
    @(negedge clk); bus.start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    checkVal("abort_state", {bus.hi, bus.lo}, 64'd0);
    checkVal("abort_flags", {62'd0, bus.busy, bus.done}, 64'd0);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) dones++;
    end
    checkVal("abort_no_done", 64'(dones), 64'd0);
    runOp(2'b00, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0);
    checkVal("mult_after_abort", {bus.hi, bus.lo}, 64'd12);

    // Random operations
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'h0;
        1:       rb = 32'($urandom_range(1, 17));
        2:       rb = 32'hFFFFFFFF - 32'($urandom_range(0, 9));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) ra = 32'h80000000;
      runOp(rop, ra, rb, 1'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
